mem_read_arbiter: RTL and testbench
===================================

# mem_read_arbiter

Shares the single downstream AXI read port to memory between the instruction cache and the data cache. Each cache issues line-refill bursts (AR then R beats); the arbiter grants one burst at a time with round-robin priority, forwards the granted address handshake downstream and routes every returning data beat back to its owner. It sits between both cache AXI read masters and the memory/AXI bridge. Write channels bypass this block.

## Interface
- ADDR_WIDTH, 26: byte address width (`ADDR_WIDTH).
- DATA_WIDTH, 32: data beat width (`DATA_WIDTH).
- LEN_WIDTH, 4: burst length field width; ARLEN carries the beat count, not count-1.
- ID_WIDTH, 4: AXI ID width.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- s_arvalid[0:1] / s_araddr[0:1] / s_arlen[0:1] / s_arid[0:1]  in  1/ADDR_WIDTH/LEN_WIDTH/ID_WIDTH per port  upstream AR requests; index 0 = I-cache, 1 = D-cache.
- s_arready[0:1]  out  1 each  upstream AR accept.
- s_rvalid[0:1], s_rlast[0:1]  out  1 each  routed R beat, last beat.
- s_rdata[0:1]  out  DATA_WIDTH each  routed read data.
- s_rready[0:1]  in  1 each  upstream R ready.
- m_arvalid  out  1; m_araddr  out  ADDR_WIDTH; m_arlen  out  LEN_WIDTH; m_arid  out  ID_WIDTH: downstream AR.
- m_arready  in  1  downstream AR accept.
- m_rvalid  in  1; m_rdata  in  DATA_WIDTH; m_rlast  in  1: downstream R beat.
- m_rready  out  1  downstream R ready.
- len_err  out  1  sticky: RLAST arrived on a beat count different from the granted ARLEN.

## Operation
- States: IDLE, ADDR, DATA. Reset: IDLE, owner=0, last_grant=1, beat_cnt=0, len_err=0.
- IDLE: if exactly one s_arvalid is high, grant it; if both, grant the index != last_grant. Latch owner, araddr, arlen, arid into registers; go to ADDR. No request: stay.
- ADDR: m_arvalid=1 with the latched fields; s_arready[owner]=m_arready. Requester must hold its AR fields stable until its s_arready. On m_arvalid & m_arready go to DATA, clear beat_cnt.
- DATA: s_rvalid[owner]=m_rvalid, s_rdata[owner]=m_rdata, s_rlast[owner]=m_rlast; m_rready=s_rready[owner]. Non-owner s_rvalid=0. On each m_rvalid & m_rready beat_cnt++. On a beat with m_rlast: if beat_cnt+1 != latched arlen set len_err; last_grant<=owner; go to IDLE.
- Outside DATA: m_rready=0, all s_rvalid=0. Outside ADDR: m_arvalid=0, all s_arready=0.
- Stray m_rvalid outside DATA: ignored (not accepted), no state change.
- beat_cnt width LEN_WIDTH+1; saturates, never wraps.
- Reset mid-burst: returns to IDLE next edge; in-flight beats are dropped (memory reset together).

## Timing
- All outputs are combinational from state and latched registers; no combinational path from s_arvalid to m_arvalid.
- Grant latency: s_arvalid high in IDLE at cycle N -> m_arvalid at N+1.
- s_arready pulses in the same cycle as m_arready.
- R beats pass through combinationally, zero added latency; one beat per cycle sustained.
- Back-to-back: after RLAST at cycle M, IDLE at M+1, next m_arvalid at M+2.
- Exactly one outstanding burst; second requester waits, its s_arvalid held.

## Structure
- Shared package (mips_core.svh): port index constants ARB_ICACHE=0, ARB_DCACHE=1; arb_state_t enum.
- Sub-module: rr_arbiter2 (2-request round-robin picker, last_grant input, grant output); rest in one module.

## Test plan
- Single I-cache request addr 0x0000100, arlen 4, m_arready immediate -> m_arvalid next cycle with 0x0000100, 4 beats routed to port 0 only, IDLE after RLAST.
- Both request same cycle after reset -> port 0 granted first; after its RLAST, port 1 granted at M+2.
- Port 1 last served, both request again -> port 0 granted (alternation over 4 bursts: 0,1,0,1).
- Owner deasserts s_rready for 3 cycles mid-burst -> m_rready low those cycles, no beat lost, beat order preserved.
- RLAST on beat 3 with arlen 4 -> len_err=1 and stays 1; arbiter still returns to IDLE.
- rst asserted during DATA beat 2 -> next cycle IDLE, all outputs at reset values, len_err=0.

Source files
------------

// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the cache-refill read arbiter.
package mem_read_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 26;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LEN_WIDTH  = 4;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned CNT_WIDTH  = LEN_WIDTH + 1;
  localparam int unsigned NUM_PORTS  = 2;

  localparam logic ARB_ICACHE = 1'b0;
  localparam logic ARB_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [ID_WIDTH-1:0]   id;
  } ar_req_t;

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// One AXI read channel pair (AR + R); master drives requests, slave drives data.
interface mem_read_arbiter_if;
  import mem_read_arbiter_pkg::*;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [ID_WIDTH-1:0]   arid;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arid, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    output arready, rvalid, rdata, rlast
  );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter2.sv
// Two-request round-robin picker: on contention the port not served last wins.
module rr_arbiter2
  import mem_read_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic                 grant_c,
  output logic                 any_c
);

  always_comb begin
    any_c = |req;
    unique case (req)
      2'b11:   grant_c = ~last_grant;
      2'b10:   grant_c = ARB_DCACHE;
      default: grant_c = ARB_ICACHE;
    endcase
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares the downstream AXI read port between I-cache and D-cache, one refill burst at a time.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_read_arbiter_if.slave  s_icache,
  mem_read_arbiter_if.slave  s_dcache,
  mem_read_arbiter_if.master m_mem,
  output logic               len_err
);

  localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;

  arb_state_t           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  ar_req_t              ar_q, ar_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 len_err_q, len_err_d;

  logic [NUM_PORTS-1:0]                 s_arvalid;
  logic [NUM_PORTS-1:0]                 s_rready;
  ar_req_t [NUM_PORTS-1:0]              s_ar;
  logic                                 grant_c;
  logic                                 grant_any_c;
  logic                                 m_rready_c;
  logic                                 r_beat_c;
  logic [SUM_WIDTH-1:0]                 beats_seen_c;
  logic [NUM_PORTS-1:0]                 s_arready_c;
  logic [NUM_PORTS-1:0]                 s_rvalid_c;
  logic [NUM_PORTS-1:0]                 s_rlast_c;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_rdata_c;

  // Gather both upstream ports into index-addressable vectors.
  assign s_arvalid = {s_dcache.arvalid, s_icache.arvalid};
  assign s_rready  = {s_dcache.rready,  s_icache.rready};
  assign s_ar[ARB_ICACHE] = ar_req_t'{addr: s_icache.araddr, len: s_icache.arlen, id: s_icache.arid};
  assign s_ar[ARB_DCACHE] = ar_req_t'{addr: s_dcache.araddr, len: s_dcache.arlen, id: s_dcache.arid};

  rr_arbiter2 u_rr (
    .req        (s_arvalid),
    .last_grant (last_grant_q),
    .grant_c    (grant_c),
    .any_c      (grant_any_c)
  );

  assign m_rready_c   = (state_q == DATA) && s_rready[owner_q];
  assign r_beat_c     = m_rready_c && m_mem.rvalid;
  assign beats_seen_c = SUM_WIDTH'(beat_cnt_q) + SUM_WIDTH'(1);

  // Next-state: grant in IDLE, address handshake in ADDR, beat counting in DATA.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ar_d         = ar_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any_c) begin
          owner_d = grant_c;
          ar_d    = s_ar[grant_c];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_mem.arready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (r_beat_c) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          if (m_mem.rlast) begin
            if (beats_seen_c != SUM_WIDTH'(ar_q.len)) begin
              len_err_d = 1'b1;
            end
            last_grant_d = owner_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= ARB_ICACHE;
      last_grant_q <= ARB_DCACHE;
      ar_q         <= '0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ar_q         <= ar_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

  // Handshake steering: only the owner sees arready / R beats, and only in its phase.
  always_comb begin
    s_arready_c = '0;
    s_rvalid_c  = '0;
    s_rlast_c   = '0;
    s_rdata_c   = '0;
    if (state_q == ADDR) begin
      s_arready_c[owner_q] = m_mem.arready;
    end
    if (state_q == DATA) begin
      s_rvalid_c[owner_q] = m_mem.rvalid;
      s_rlast_c[owner_q]  = m_mem.rlast;
      s_rdata_c[owner_q]  = m_mem.rdata;
    end
  end

  assign m_mem.arvalid = (state_q == ADDR);
  assign m_mem.araddr  = ar_q.addr;
  assign m_mem.arlen   = ar_q.len;
  assign m_mem.arid    = ar_q.id;
  assign m_mem.rready  = m_rready_c;

  assign s_icache.arready = s_arready_c[ARB_ICACHE];
  assign s_icache.rvalid  = s_rvalid_c[ARB_ICACHE];
  assign s_icache.rlast   = s_rlast_c[ARB_ICACHE];
  assign s_icache.rdata   = s_rdata_c[ARB_ICACHE];
  assign s_dcache.arready = s_arready_c[ARB_DCACHE];
  assign s_dcache.rvalid  = s_rvalid_c[ARB_DCACHE];
  assign s_dcache.rlast   = s_rlast_c[ARB_DCACHE];
  assign s_dcache.rdata   = s_rdata_c[ARB_DCACHE];

  assign len_err = len_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: arbitration table, corner sequences, random traffic vs. model.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic len_err;
  int   checks = 0;
  int   errors = 0;

  mem_read_arbiter_if ic ();
  mem_read_arbiter_if dc ();
  mem_read_arbiter_if mm ();

  mem_read_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .s_icache (ic),
    .s_dcache (dc),
    .m_mem    (mm),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] req;
    int         len;
    logic       exp_port;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic arready_of(input logic p);
    return p ? dc.arready : ic.arready;
  endfunction
  function automatic logic rvalid_of(input logic p);
    return p ? dc.rvalid : ic.rvalid;
  endfunction
  function automatic logic rlast_of(input logic p);
    return p ? dc.rlast : ic.rlast;
  endfunction
  function automatic logic [31:0] rdata_of(input logic p);
    return p ? dc.rdata : ic.rdata;
  endfunction

  task automatic drive_ar(input logic p, input logic v, input logic [25:0] a,
                          input logic [3:0] l, input logic [3:0] id);
    if (p) begin
      dc.arvalid = v; dc.araddr = a; dc.arlen = l; dc.arid = id;
    end else begin
      ic.arvalid = v; ic.araddr = a; ic.arlen = l; ic.arid = id;
    end
  endtask

  task automatic idle_inputs();
    drive_ar(1'b0, 1'b0, 26'd0, 4'd0, 4'd0);
    drive_ar(1'b1, 1'b0, 26'd0, 4'd0, 4'd0);
    ic.rready  = 1'b1;
    dc.rready  = 1'b1;
    mm.arready = 1'b0;
    mm.rvalid  = 1'b0;
    mm.rdata   = 32'd0;
    mm.rlast   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One burst from IDLE with immediate arready; nbeats != len exercises length errors.
  task automatic do_burst(input string nm, input logic [1:0] req, input int len, input int nbeats,
                          input logic gp, input logic [25:0] a0, input logic [25:0] a1,
                          input logic exp_lerr);
    logic [25:0] ga;
    ga = gp ? a1 : a0;
    drive_ar(1'b0, req[0], a0, 4'(len), 4'h1);
    drive_ar(1'b1, req[1], a1, 4'(len), 4'h2);
    mm.arready = 1'b1;
    #1;
    chk({nm, "_no_early_arvalid"}, 64'(mm.arvalid), 64'd0);
    tick();
    chk({nm, "_arvalid"}, 64'(mm.arvalid), 64'd1);
    chk({nm, "_araddr"}, 64'(mm.araddr), 64'(ga));
    chk({nm, "_arlen"}, 64'(mm.arlen), 64'(len));
    chk({nm, "_arid"}, 64'(mm.arid), gp ? 64'd2 : 64'd1);
    chk({nm, "_arready_owner"}, 64'(arready_of(gp)), 64'd1);
    chk({nm, "_arready_other"}, 64'(arready_of(~gp)), 64'd0);
    tick();
    ic.arvalid = 1'b0;
    dc.arvalid = 1'b0;
    mm.arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      mm.rvalid = 1'b1;
      mm.rdata  = {6'(b), ga};
      mm.rlast  = (b == nbeats - 1);
      #1;
      chk({nm, "_rvalid_owner"}, 64'(rvalid_of(gp)), 64'd1);
      chk({nm, "_rvalid_other"}, 64'(rvalid_of(~gp)), 64'd0);
      chk({nm, "_rdata"}, 64'(rdata_of(gp)), 64'({6'(b), ga}));
      chk({nm, "_rlast"}, 64'(rlast_of(gp)), (b == nbeats - 1) ? 64'd1 : 64'd0);
      chk({nm, "_m_rready"}, 64'(mm.rready), 64'd1);
      tick();
    end
    mm.rvalid = 1'b0;
    mm.rlast  = 1'b0;
    mm.rdata  = 32'd0;
    #1;
    chk({nm, "_idle_arvalid"}, 64'(mm.arvalid), 64'd0);
    chk({nm, "_idle_rready"}, 64'(mm.rready), 64'd0);
    chk({nm, "_len_err"}, 64'(len_err), 64'(exp_lerr));
  endtask

  // Random traffic from both caches and a randomly stalling memory, checked against transaction rules.
  task automatic run_random(input int ncyc);
    logic        pend [2];
    logic        outst[2];
    logic [25:0] ra   [2];
    logic [3:0]  rl   [2];
    logic [3:0]  rid  [2];
    int          rbeat[2];
    int          done [2];
    logic        rr   [2];
    logic        free, arph, datph, g, last_srv, mv, mlast, bus_ar, bus_r;
    int          mem_left, mem_beat;
    logic [25:0] mem_addr;
    logic [31:0] md;
    bit          drained;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; outst[p] = 1'b0; ra[p] = '0; rl[p] = '0; rid[p] = '0;
      rbeat[p] = 0; done[p] = 0; rr[p] = 1'b1;
    end
    free = 1'b1; arph = 1'b0; datph = 1'b0; g = 1'b0; last_srv = 1'b1;
    mem_left = 0; mem_beat = 0; mem_addr = '0;
    drained = 1'b0;
    for (int c = 0; c < ncyc + 2000; c++) begin
      if (c >= ncyc && !pend[0] && !pend[1] && !outst[0] && !outst[1] && free) begin
        drained = 1'b1;
        break;
      end
      for (int p = 0; p < 2; p++) begin
        if (c < ncyc && !pend[p] && !outst[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          ra[p]   = 26'($urandom);
          rl[p]   = 4'($urandom_range(1, 15));
          rid[p]  = 4'($urandom);
        end
        rr[p] = ($urandom_range(0, 3) != 0);
        drive_ar(1'(p), pend[p], ra[p], rl[p], rid[p]);
      end
      ic.rready  = rr[0];
      dc.rready  = rr[1];
      mm.arready = 1'($urandom_range(0, 1));
      if (mem_left > 0) begin
        mv    = ($urandom_range(0, 2) != 0);
        md    = {6'(mem_beat), mem_addr};
        mlast = (mem_left == 1);
      end else begin
        mv    = ($urandom_range(0, 7) == 0);
        md    = $urandom;
        mlast = 1'($urandom_range(0, 1));
      end
      mm.rvalid = mv;
      mm.rdata  = md;
      mm.rlast  = mlast;
      #1;
      chk("rnd_arvalid", 64'(mm.arvalid), 64'(arph));
      if (arph) begin
        chk("rnd_araddr", 64'(mm.araddr), 64'(ra[g]));
        chk("rnd_arlen", 64'(mm.arlen), 64'(rl[g]));
        chk("rnd_arid", 64'(mm.arid), 64'(rid[g]));
        chk("rnd_arready_owner", 64'(arready_of(g)), 64'(mm.arready));
        chk("rnd_arready_other", 64'(arready_of(~g)), 64'd0);
      end else begin
        chk("rnd_arready_quiet", 64'({ic.arready, dc.arready}), 64'd0);
      end
      if (datph) begin
        chk("rnd_m_rready", 64'(mm.rready), 64'(rr[g]));
        chk("rnd_rvalid_owner", 64'(rvalid_of(g)), 64'(mv));
        chk("rnd_rvalid_other", 64'(rvalid_of(~g)), 64'd0);
      end else begin
        chk("rnd_m_rready_quiet", 64'(mm.rready), 64'd0);
        chk("rnd_rvalid_quiet", 64'({ic.rvalid, dc.rvalid}), 64'd0);
      end
      bus_ar = arph && mm.arready;
      bus_r  = datph && mv && rr[g];
      if (free && (pend[0] || pend[1])) begin
        g    = (pend[0] && pend[1]) ? ~last_srv : pend[1];
        free = 1'b0;
        arph = 1'b1;
      end else if (bus_ar) begin
        arph     = 1'b0;
        datph    = 1'b1;
        pend[g]  = 1'b0;
        outst[g] = 1'b1;
        rbeat[g] = 0;
        mem_left = int'(rl[g]);
        mem_beat = 0;
        mem_addr = ra[g];
      end else if (bus_r) begin
        chk("rnd_rdata", 64'(rdata_of(g)), 64'({6'(rbeat[g]), ra[g]}));
        chk("rnd_rlast", 64'(rlast_of(g)), 64'(mlast));
        rbeat[g]++;
        mem_beat++;
        mem_left--;
        if (mlast) begin
          datph    = 1'b0;
          outst[g] = 1'b0;
          last_srv = g;
          done[g]++;
          free     = 1'b1;
        end
      end
      tick();
    end
    idle_inputs();
    chk("rnd_drained", 64'(drained), 64'd1);
    chk("rnd_icache_served", 64'(done[0] > 0), 64'd1);
    chk("rnd_dcache_served", 64'(done[1] > 0), 64'd1);
    chk("rnd_len_err", 64'(len_err), 64'd0);
  endtask

  initial begin
    vec_t        vecs[9];
    logic [25:0] a0, a1;
    int          beat;

    vecs[0] = '{req: 2'b01, len: 4,  exp_port: 1'b0};
    vecs[1] = '{req: 2'b11, len: 2,  exp_port: 1'b1};
    vecs[2] = '{req: 2'b11, len: 3,  exp_port: 1'b0};
    vecs[3] = '{req: 2'b11, len: 1,  exp_port: 1'b1};
    vecs[4] = '{req: 2'b11, len: 8,  exp_port: 1'b0};
    vecs[5] = '{req: 2'b10, len: 5,  exp_port: 1'b1};
    vecs[6] = '{req: 2'b01, len: 15, exp_port: 1'b0};
    vecs[7] = '{req: 2'b11, len: 2,  exp_port: 1'b1};
    vecs[8] = '{req: 2'b11, len: 4,  exp_port: 1'b0};

    do_reset();
    #1;
    chk("reset_arvalid", 64'(mm.arvalid), 64'd0);
    chk("reset_rready", 64'(mm.rready), 64'd0);
    chk("reset_araddr", 64'(mm.araddr), 64'd0);
    chk("reset_arready", 64'({ic.arready, dc.arready}), 64'd0);
    chk("reset_rvalid", 64'({ic.rvalid, dc.rvalid}), 64'd0);
    chk("reset_len_err", 64'(len_err), 64'd0);

    // Both request right after reset: I-cache first, D-cache granted two cycles after RLAST.
    drive_ar(1'b0, 1'b1, 26'h0000400, 4'd2, 4'h3);
    drive_ar(1'b1, 1'b1, 26'h0300000, 4'd1, 4'h4);
    mm.arready = 1'b1;
    tick();
    chk("b2b_first_araddr", 64'(mm.araddr), 64'h400);
    chk("b2b_first_arready", 64'({dc.arready, ic.arready}), 64'b01);
    tick();
    ic.arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mm.rvalid = 1'b1;
      mm.rdata  = 32'(b + 7);
      mm.rlast  = (b == 1);
      #1;
      chk("b2b_first_rdata", 64'(ic.rdata), 64'(b + 7));
      chk("b2b_first_dc_quiet", 64'(dc.rvalid), 64'd0);
      tick();
    end
    mm.rvalid = 1'b0;
    mm.rlast  = 1'b0;
    #1;
    chk("b2b_gap_arvalid", 64'(mm.arvalid), 64'd0);
    tick();
    chk("b2b_second_arvalid", 64'(mm.arvalid), 64'd1);
    chk("b2b_second_araddr", 64'(mm.araddr), 64'h0300000);
    chk("b2b_second_arready", 64'({dc.arready, ic.arready}), 64'b10);
    tick();
    dc.arvalid = 1'b0;
    mm.arready = 1'b0;
    mm.rvalid  = 1'b1;
    mm.rdata   = 32'hCAFE0001;
    mm.rlast   = 1'b1;
    #1;
    chk("b2b_second_rdata", 64'(dc.rdata), 64'hCAFE0001);
    chk("b2b_second_ic_quiet", 64'(ic.rvalid), 64'd0);
    tick();
    idle_inputs();

    // Arbitration table; alternation depends on the burst served before each entry.
    for (int i = 0; i < 9; i++) begin
      a0 = 26'h0000100 + 26'(i * 64);
      a1 = 26'h0200000 + 26'(i * 64);
      do_burst($sformatf("vec%0d", i), vecs[i].req, vecs[i].len, vecs[i].len,
               vecs[i].exp_port, a0, a1, 1'b0);
    end

    // Owner holds off rready for three cycles mid-burst.
    drive_ar(1'b1, 1'b1, 26'h0150000, 4'd6, 4'h7);
    mm.arready = 1'b1;
    tick();
    tick();
    dc.arvalid = 1'b0;
    mm.arready = 1'b0;
    beat = 0;
    for (int c = 0; c < 12 && beat < 6; c++) begin
      dc.rready = !(c >= 2 && c <= 4);
      mm.rvalid = 1'b1;
      mm.rdata  = {6'(beat), 26'h0150000};
      mm.rlast  = (beat == 5);
      #1;
      chk("stall_m_rready", 64'(mm.rready), (c >= 2 && c <= 4) ? 64'd0 : 64'd1);
      chk("stall_rdata", 64'(dc.rdata), 64'({6'(beat), 26'h0150000}));
      chk("stall_ic_quiet", 64'(ic.rvalid), 64'd0);
      if (dc.rready) beat++;
      tick();
    end
    chk("stall_all_beats", 64'(beat), 64'd6);
    idle_inputs();
    #1;
    chk("stall_back_idle", 64'(mm.rready), 64'd0);

    // Stray R beats while idle are not accepted and do not disturb the next burst.
    mm.rvalid = 1'b1;
    mm.rlast  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stray_m_rready", 64'(mm.rready), 64'd0);
      chk("stray_rvalid", 64'({ic.rvalid, dc.rvalid}), 64'd0);
      tick();
    end
    idle_inputs();
    do_burst("post_stray", 2'b10, 3, 3, 1'b1, 26'h0000800, 26'h0000900, 1'b0);

    do_reset();
    run_random(3000);

    // Early RLAST sets the sticky length error; a good burst afterwards leaves it set.
    do_burst("lenerr", 2'b01, 4, 3, 1'b0, 26'h0000A00, 26'h0000B00, 1'b1);
    tick();
    chk("lenerr_hold", 64'(len_err), 64'd1);
    do_burst("lenerr_sticky", 2'b10, 2, 2, 1'b1, 26'h0000C00, 26'h0000D00, 1'b1);

    // Reset during the third data beat returns everything to reset values.
    drive_ar(1'b0, 1'b1, 26'h0000E00, 4'd4, 4'h5);
    mm.arready = 1'b1;
    tick();
    tick();
    ic.arvalid = 1'b0;
    mm.arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mm.rvalid = 1'b1;
      mm.rdata  = 32'(b);
      #1;
      chk("rstmid_beat_routed", 64'(ic.rvalid), 64'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rstmid_arvalid", 64'(mm.arvalid), 64'd0);
    chk("rstmid_rready", 64'(mm.rready), 64'd0);
    chk("rstmid_araddr", 64'(mm.araddr), 64'd0);
    chk("rstmid_arlen", 64'(mm.arlen), 64'd0);
    chk("rstmid_rvalid", 64'({ic.rvalid, dc.rvalid}), 64'd0);
    chk("rstmid_arready", 64'({ic.arready, dc.arready}), 64'd0);
    chk("rstmid_len_err", 64'(len_err), 64'd0);
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
